rs_seg_addsub_pipe: RTL and testbench
=====================================

Name: rs_seg_addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit for operands wider than one physical carry chain.
- Splits a WIDTH-bit operation into NSEG = ceil(WIDTH/SEG_WIDTH) carry-chain segments.
- Each segment's carry-out is registered before it feeds the next segment, so no combinational chain exceeds SEG_WIDTH bits.
- Sits between datapath producers and consumers behind a valid/ready handshake; replaces the single unregistered wide chain for widths beyond MAX_CARRY_CHAIN.

Parameters:
- WIDTH, 64, operand and result width in bits (>=1).
- SEG_WIDTH, 32, bits per carry-chain segment (1..MAX_CARRY_CHAIN).
- SIGNED, 0, 1 = compute the signed overflow flag OV; 0 = OV tied to 0.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  carry-in.
- BI  input  1  invert B (subtract when CI=1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- Y  output  WIDTH  A + (BI ? ~B : B) + CI, modulo 2^WIDTH.
- CO  output  1  carry out of bit WIDTH-1.
- OV  output  1  signed overflow: carry into MSB XOR carry out of MSB (SIGNED=1 only).

Behaviour:
- Clock and reset: one clock CLK; reset RESET is synchronous, active-high. All state updates on the rising CLK edge.
- Reset values: every stage valid bit = 0, out_valid = 0, Y = 0, CO = 0, OV = 0. in_ready = 1 the cycle after reset deasserts.
- Pipeline: NSEG stages.
  - Stage k (0-based) adds bits [k*SEG_WIDTH +: SEG_WIDTH] of A and B', using the carry registered by stage k-1 (stage 0 uses CI).
  - The last segment is WIDTH - (NSEG-1)*SEG_WIDTH bits wide.
- Skew/deskew:
  - Input skew registers delay the upper segment operands by k cycles.
  - Output deskew registers delay the lower result slices.
  - All bits of Y appear together.
- Latency: exactly NSEG cycles from the accepting cycle to out_valid, with no stalls. Throughput: 1 beat/cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - A beat is accepted when in_valid && in_ready.
  - All stage registers, including valid bits, load only when advance = 1.
  - While advance = 0, every register holds, and Y/CO/OV/out_valid are stable.
- Bubbles: an unaccepted cycle inserts valid = 0 into stage 0. Bubbles propagate and are never emitted (out_valid = 0).
- NSEG = 1: single registered stage, latency 1.
- Arithmetic:
  - B' = BI ? ~B : B.
  - CO = carry out of the top segment.
  - OV = c_in_msb ^ CO when SIGNED = 1, else 0.
  - Overflow/wrap is modulo 2^WIDTH; the unit never saturates.
- Mid-operation reset: all in-flight beats are discarded; out_valid = 0 the following cycle, regardless of out_ready.
- Simultaneous output accept and input accept in one cycle: both take effect; no beat is lost or duplicated.
- X/Z on A/B while in_valid = 0 must not reach out_valid.

Decomposition:
- Package rs_arith_pkg holds:
  - function nseg(width, seg) = ceil(width/seg);
  - function seg_lsb(k, seg);
  - constant MAX_CARRY_CHAIN_DEFAULT.
- Sub-module rs_adder_segment (parameter W): one registered carry-chain slice.
  - Inputs: a, b, cin, en.
  - Registered outputs: sum, cout, cmsb_in.
  - Synchronous reset clears all outputs.
  - Instantiated NSEG times in a generate loop.
  - The maps onto ADDER_CARRY cells.

Test Plan:
- WIDTH=64, SEG_WIDTH=32: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, CI=0, BI=0 -> after 2 cycles Y=0, CO=1; carry crosses the segment boundary.
- WIDTH=64, SIGNED=1: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, CI=0 -> Y=64'h8000_0000_0000_0000, OV=1, CO=0.
- Subtract: A=100, B=101, BI=1, CI=1 -> Y=64'hFFFF_FFFF_FFFF_FFFF, CO=0; with A=101, B=100 -> Y=1, CO=1.
- Back-to-back stream of 16 random beats, out_ready toggling pseudo-randomly -> results in order, no loss or duplication, each held stable while out_ready=0; compare against a 65-bit reference model.
- RESET asserted for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, Y/CO/OV=0, no stale beat emitted afterward.
- WIDTH=40, SEG_WIDTH=16 (NSEG=3, top segment 8 bits): A=40'hFF_FFFF_FFFF, B=1 -> Y=0, CO=1 after exactly 3 cycles.

Source files
------------

// File: rtl/rs_arith_pkg.sv
// rs_arith_pkg: shared sizing helpers for segmented carry-chain arithmetic.
//   nseg(width, seg)  number of carry-chain segments needed for a width-bit operand
//   seg_lsb(k, seg)   bit index of the least significant bit of segment k
//   MAX_CARRY_CHAIN_DEFAULT  longest carry chain a single segment may use
package rs_arith_pkg;

  localparam int MAX_CARRY_CHAIN_DEFAULT = 32;

  function automatic int nseg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  function automatic int seg_lsb(input int k, input int seg);
    return k * seg;
  endfunction

endpackage

// File: rtl/rs_adder_segment.sv
// rs_adder_segment: one registered carry-chain slice of a segmented adder.
// Ports:
//   clk, reset      clock and synchronous active-high reset (clears all outputs)
//   en              load enable; every output holds while en = 0
//   a, b, cin       slice operands and carry-in
//   sum, cout       registered slice sum and carry-out
//   cmsb_in         registered carry into the slice MSB (for signed overflow)
module rs_adder_segment #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb_in
);

  logic [W:0] full;
  logic       cmsb_next;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  // The sum bit of the MSB is a ^ b ^ carry_in, so the carry into it falls out directly.
  assign cmsb_next = a[W-1] ^ b[W-1] ^ full[W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sum     <= '0;
      cout    <= 1'b0;
      cmsb_in <= 1'b0;
    end else if (en) begin
      sum     <= full[W-1:0];
      cout    <= full[W];
      cmsb_in <= cmsb_next;
    end
  end

endmodule

// File: rtl/rs_seg_addsub_pipe.sv
// rs_seg_addsub_pipe: pipelined add/subtract split into NSEG registered carry-chain
// segments. Upper operand slices are skewed by k cycles so each segment meets the
// carry registered by the segment below; lower result slices are deskewed so all of
// Y appears together, NSEG cycles after acceptance.
// Ports:
//   CLK, RESET            clock and synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = !out_valid || out_ready)
//   A, B, CI, BI          operands; Y = A + (BI ? ~B : B) + CI mod 2^WIDTH
//   out_valid / out_ready result handshake
//   Y, CO, OV             result, carry out of MSB, signed overflow (SIGNED=1 only)
module rs_seg_addsub_pipe
  import rs_arith_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = MAX_CARRY_CHAIN_DEFAULT,
  parameter int SIGNED    = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV
);

  localparam int NSEG = nseg(WIDTH, SEG_WIDTH);

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] b_g;
  logic             ci_g;
  logic [NSEG-1:0]  v_r;
  logic [NSEG-1:0]  cout_v;
  logic [NSEG-1:0]  cmsb_v;
  logic             unused_cmsb;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign out_valid = v_r[NSEG-1];

  // Bubbles carry zero operands so undriven inputs never wander into the datapath.
  assign a_g  = accept ? A : '0;
  assign b_g  = accept ? (BI ? ~B : B) : '0;
  assign ci_g = accept & CI;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      v_r <= '0;
    end else if (advance) begin
      v_r <= (v_r << 1) | NSEG'(accept);
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LSB = seg_lsb(k, SEG_WIDTH);
    localparam int SW  = (k == NSEG - 1) ? WIDTH - LSB : SEG_WIDTH;
    localparam int DSK = NSEG - 1 - k;

    logic [SW-1:0] a_seg;
    logic [SW-1:0] b_seg;
    logic [SW-1:0] sum_seg;
    logic          cin_seg;

    if (k == 0) begin : g_head
      assign a_seg   = a_g[LSB +: SW];
      assign b_seg   = b_g[LSB +: SW];
      assign cin_seg = ci_g;
    end else begin : g_skew
      logic [SW-1:0] a_dly [k];
      logic [SW-1:0] b_dly [k];

      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int i = 0; i < k; i++) begin
            a_dly[i] <= '0;
            b_dly[i] <= '0;
          end
        end else if (advance) begin
          a_dly[0] <= a_g[LSB +: SW];
          b_dly[0] <= b_g[LSB +: SW];
          for (int i = 1; i < k; i++) begin
            a_dly[i] <= a_dly[i-1];
            b_dly[i] <= b_dly[i-1];
          end
        end
      end

      assign a_seg   = a_dly[k-1];
      assign b_seg   = b_dly[k-1];
      assign cin_seg = cout_v[k-1];
    end

    rs_adder_segment #(.W(SW)) u_seg (
      .clk     (CLK),
      .reset   (RESET),
      .en      (advance),
      .a       (a_seg),
      .b       (b_seg),
      .cin     (cin_seg),
      .sum     (sum_seg),
      .cout    (cout_v[k]),
      .cmsb_in (cmsb_v[k])
    );

    if (DSK == 0) begin : g_top
      assign Y[LSB +: SW] = sum_seg;
    end else begin : g_deskew
      logic [SW-1:0] y_dly [DSK];

      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int i = 0; i < DSK; i++) y_dly[i] <= '0;
        end else if (advance) begin
          y_dly[0] <= sum_seg;
          for (int i = 1; i < DSK; i++) y_dly[i] <= y_dly[i-1];
        end
      end

      assign Y[LSB +: SW] = y_dly[DSK-1];
    end
  end

  assign CO = cout_v[NSEG-1];
  assign OV = (SIGNED != 0) ? (cmsb_v[NSEG-1] ^ cout_v[NSEG-1]) : 1'b0;

  // Only the top segment's MSB carry matters; lower ones are structural leftovers.
  assign unused_cmsb = ^cmsb_v;

endmodule

// File: tb/tb_rs_seg_addsub_pipe.sv
module tb_rs_seg_addsub_pipe;

  typedef struct {
    logic [63:0] y;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        bi;
    logic [63:0] y;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [39:0] a;
    logic [39:0] y;
    logic        co;
    logic        ov;
  } vec40_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, ci, bi, out_valid, out_ready, co, ov;
  logic [63:0] a, b, y;

  logic        in_valid40, in_ready40, out_valid40, co40, ov40;
  logic [39:0] a40, b40, y40;

  always #5 clk = ~clk;

  rs_seg_addsub_pipe #(.WIDTH(64), .SEG_WIDTH(32), .SIGNED(1)) dut (
    .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .CI(ci), .BI(bi), .out_valid(out_valid), .out_ready(out_ready),
    .Y(y), .CO(co), .OV(ov)
  );

  rs_seg_addsub_pipe #(.WIDTH(40), .SEG_WIDTH(16), .SIGNED(1)) dut40 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid40), .in_ready(in_ready40),
    .A(a40), .B(b40), .CI(1'b0), .BI(1'b0), .out_valid(out_valid40), .out_ready(1'b1),
    .Y(y40), .CO(co40), .OV(ov40)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  exp_t        pend;
  logic        last_acc;
  logic        chk_lat = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        hold = 1'b0;
  logic [63:0] hold_y;
  logic        hold_co, hold_ov;
  vec_t        tbl [12];
  vec40_t      tbl40 [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] va, input logic [63:0] vb,
                                 input logic vci, input logic vbi);
    exp_t        e;
    logic [64:0] s;
    logic [63:0] bp;
    bp   = vbi ? ~vb : vb;
    s    = {1'b0, va} + {1'b0, bp} + {64'd0, vci};
    e.y  = s[63:0];
    e.co = s[64];
    e.ov = (va[63] == bp[63]) && (e.y[63] != va[63]);
    e.acc = 0;
    return e;
  endfunction

  // One clock: check outputs and note acceptance at the negedge, then step past posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_y", y, hold_y);
        chk("hold_co", {63'd0, co}, {63'd0, hold_co});
        chk("hold_ov", {63'd0, ov}, {63'd0, hold_ov});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y=%h with empty scoreboard", y);
        end else begin
          e = sb.pop_front();
          chk("y", y, e.y);
          chk("co", {63'd0, co}, {63'd0, e.co});
          chk("ov", {63'd0, ov}, {63'd0, e.ov});
          if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      hold    = out_valid && !out_ready;
      hold_y  = y;
      hold_co = co;
      hold_ov = ov;
    end
    last_acc = in_valid && in_ready && !rst;
    if (last_acc) begin
      pend.acc = cyc;
      sb.push_back(pend);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [63:0] va, input logic [63:0] vb,
                      input logic vci, input logic vbi, input exp_t e);
    a = va; b = vb; ci = vci; bi = vbi;
    pend = e;
    in_valid = 1'b1;
    last_acc = 1'b0;
    for (int t = 0; t < 100 && !last_acc; t++) tick();
    in_valid = 1'b0;
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    exp_t        e;
    logic [63:0] ra, rb;
    logic        rci, rbi;
    int          stale, n;

    tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[2]  = '{64'd100, 64'd101, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[3]  = '{64'd101, 64'd100, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0};
    tbl[4]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    tbl[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[6]  = '{64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[7]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[8]  = '{64'd5, 64'd3, 1'b1, 1'b0, 64'd9, 1'b0, 1'b0};
    tbl[9]  = '{64'd10, 64'd3, 1'b0, 1'b1, 64'd6, 1'b1, 1'b0};
    tbl[10] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[11] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};

    tbl40[0] = '{40'hFF_FFFF_FFFF, 40'h00_0000_0000, 1'b1, 1'b0};
    tbl40[1] = '{40'h00_0000_FFFF, 40'h00_0001_0000, 1'b0, 1'b0};
    tbl40[2] = '{40'h00_FFFF_FFFF, 40'h01_0000_0000, 1'b0, 1'b0};
    tbl40[3] = '{40'h7F_FFFF_FFFF, 40'h80_0000_0000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; bi = 1'b0; out_ready = 1'b1;
    in_valid40 = 1'b0; a40 = '0; b40 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y", y, 64'd0);
    chk("rst_co", {63'd0, co}, 64'd0);
    chk("rst_ov", {63'd0, ov}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid40", {63'd0, out_valid40}, 64'd0);

    // Back-to-back directed vectors, out_ready held high, latency checked.
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e.y = tbl[i].y; e.co = tbl[i].co; e.ov = tbl[i].ov; e.acc = 0;
      send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].bi, e);
    end
    drain();
    chk_lat = 1'b0;

    // Random stream with gaps and pseudo-random back-pressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rci = 1'($urandom_range(0, 1));
      rbi = 1'($urandom_range(0, 1));
      if (i % 4 == 3) rb = ~ra;
      repeat ($urandom_range(0, 1)) tick();
      send(ra, rb, rci, rbi, model(ra, rb, rci, rbi));
    end
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset with two beats in flight and the output stalled.
    out_ready = 1'b0;
    send(64'd7, 64'd8, 1'b0, 1'b0, model(64'd7, 64'd8, 1'b0, 1'b0));
    send(64'd9, 64'd1, 1'b0, 1'b0, model(64'd9, 64'd1, 1'b0, 1'b0));
    chk("inflight_out_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_y", y, 64'd0);
    chk("midrst_co", {63'd0, co}, 64'd0);
    chk("midrst_ov", {63'd0, ov}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("no_stale_beat", 64'(stale), 64'd0);

    // Three-segment instance: carry ripples through registered segment carries.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      a40 = tbl40[i].a; b40 = 40'd1; in_valid40 = 1'b1;
      @(negedge clk);
      chk("in_ready40", {63'd0, in_ready40}, 64'd1);
      @(posedge clk);
      #1 in_valid40 = 1'b0;
      n = 0;
      for (int t = 1; t <= 10; t++) begin
        @(negedge clk);
        if (out_valid40) begin
          n = t;
          break;
        end
      end
      chk("latency40", 64'(n), 64'd3);
      chk("y40", {24'd0, y40}, {24'd0, tbl40[i].y});
      chk("co40", {63'd0, co40}, {63'd0, tbl40[i].co});
      chk("ov40", {63'd0, ov40}, {63'd0, tbl40[i].ov});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
